// File: rtl/vx_mem_responder_pkg.sv
// rtl/vx_mem_responder_pkg.sv - default geometry shared by the memory responder slice
package vx_mem_responder_pkg;

  localparam int DEF_DATA_WIDTH = 512;
  localparam int DEF_ADDR_WIDTH = 26;
  localparam int DEF_TAG_WIDTH  = 8;
  localparam int DEF_SIZE_LOG2  = 10;
  localparam int DEF_LATENCY    = 4;
  localparam int DEF_QUEUE_SIZE = 4;

endpackage

// File: rtl/vx_mem_responder_fifo_queue.sv
// rtl/vx_mem_responder_fifo_queue.sv - in-order response queue with fall-through when empty
module vx_mem_responder_fifo_queue #(
  parameter int DATAW = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic             valid,
  output logic [DATAW-1:0] data_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATAW-1:0] entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             store_push;
  logic             store_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count == '0);

  // An entry arriving into an empty queue while being popped passes straight through.
  assign store_push = push && !(empty && pop);
  assign store_pop  = pop && !empty;

  assign valid    = !empty || push;
  assign data_out = empty ? data_in : entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (store_push) begin
      entries[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (store_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (store_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({store_push, store_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vx_mem_responder.sv
// rtl/vx_mem_responder.sv - fixed-latency backing-store memory model with credit-limited reads
module vx_mem_responder
  import vx_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int SIZE_LOG2  = DEF_SIZE_LOG2,
  parameter int LATENCY    = DEF_LATENCY,
  parameter int QUEUE_SIZE = DEF_QUEUE_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << SIZE_LOG2;
  localparam int CNT_W = $clog2(QUEUE_SIZE + 1);
  localparam int QW    = DATA_WIDTH + TAG_WIDTH;

  logic [DATA_WIDTH-1:0] store [DEPTH];
  logic [SIZE_LOG2-1:0]  word_addr;
  logic                  unused_addr_bits;

  logic                  req_fire;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  rsp_fire;
  logic [CNT_W-1:0]      credit_cnt;

  logic [LATENCY-1:0]    pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data [LATENCY];
  logic [TAG_WIDTH-1:0]  pipe_tag  [LATENCY];

  logic                  q_valid;
  logic [QW-1:0]         q_data;

  // Upper address bits alias onto the same store.
  assign word_addr        = mem_req_addr[SIZE_LOG2-1:0];
  assign unused_addr_bits = ^mem_req_addr;

  assign mem_req_ready = !reset && (credit_cnt < CNT_W'(QUEUE_SIZE));
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rd_fire       = req_fire && !mem_req_rw;
  assign wr_fire       = req_fire && mem_req_rw;
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_req_byteen[b]) begin
          store[word_addr][b*8 +: 8] <= mem_req_data[b*8 +: 8];
        end
      end
    end
  end

  // Credits cover everything from acceptance until the response is taken, so the
  // queue can always absorb whatever leaves the delay pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_cnt <= '0;
    end else begin
      case ({rd_fire, rsp_fire})
        2'b10:   credit_cnt <= credit_cnt + CNT_W'(1);
        2'b01:   credit_cnt <= credit_cnt - CNT_W'(1);
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= rd_fire;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // Read data is sampled in the accept cycle, so it sees all earlier writes.
  always_ff @(posedge clk) begin
    if (rd_fire) begin
      pipe_data[0] <= store[word_addr];
      pipe_tag[0]  <= mem_req_tag;
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
      pipe_tag[i]  <= pipe_tag[i-1];
    end
  end

  vx_mem_responder_fifo_queue #(
    .DATAW (QW),
    .DEPTH (QUEUE_SIZE)
  ) rsp_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (pipe_valid[LATENCY-1]),
    .pop      (rsp_fire),
    .data_in  ({pipe_data[LATENCY-1], pipe_tag[LATENCY-1]}),
    .valid    (q_valid),
    .data_out (q_data)
  );

  assign mem_rsp_valid = q_valid && !reset;
  assign mem_rsp_data  = q_data[QW-1:TAG_WIDTH];
  assign mem_rsp_tag   = q_data[TAG_WIDTH-1:0];

endmodule

// File: tb/tb_vx_mem_responder.sv
// tb/tb_vx_mem_responder.sv - randomized self-checking bench for vx_mem_responder
module tb_vx_mem_responder;

  localparam int DW    = 64;
  localparam int AW    = 12;
  localparam int TW    = 8;
  localparam int SL    = 6;
  localparam int LAT   = 4;
  localparam int QS    = 5;
  localparam int BE    = DW / 8;
  localparam int DEPTH = 1 << SL;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req_valid;
  logic          mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [BE-1:0] mem_req_byteen;
  logic [DW-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready;

  always #5 clk = ~clk;

  vx_mem_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TAG_WIDTH  (TW),
    .SIZE_LOG2  (SL),
    .LATENCY    (LAT),
    .QUEUE_SIZE (QS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } rsp_t;

  int            n_checks = 0;
  int            n_fails  = 0;
  logic [DW-1:0] model_mem [DEPTH];
  rsp_t          exp_q [$];
  int            pre_outstanding;
  logic          s_ready;
  logic          s_rv;
  logic [DW-1:0] s_rd;
  logic [TW-1:0] s_rt;

  // One clock cycle: apply inputs after the falling edge, sample just after, update the model.
  task automatic drive(input logic rst, input logic v, input logic rw, input logic [AW-1:0] a,
                       input logic [BE-1:0] be, input logic [DW-1:0] d, input logic [TW-1:0] t,
                       input logic rr);
    rsp_t e;
    @(negedge clk);
    reset          = rst;
    mem_req_valid  = v;
    mem_req_rw     = rw;
    mem_req_addr   = a;
    mem_req_byteen = be;
    mem_req_data   = d;
    mem_req_tag    = t;
    mem_rsp_ready  = rr;
    #1;
    s_ready = mem_req_ready;
    s_rv    = mem_rsp_valid;
    s_rd    = mem_rsp_data;
    s_rt    = mem_rsp_tag;
    pre_outstanding = exp_q.size();
    if (v && s_ready) begin
      if (rw) begin
        for (int b = 0; b < BE; b++)
          if (be[b]) model_mem[a[SL-1:0]][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        e.data = model_mem[a[SL-1:0]];
        e.tag  = t;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, rr);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
      n_checks++;
      if (s_ready !== 1'b0) begin n_fails++; $display("FAIL reset_ready got=%0b want=0", s_ready); end
      n_checks++;
      if (s_rv !== 1'b0) begin n_fails++; $display("FAIL reset_rsp_valid got=%0b want=0", s_rv); end
    end
    idle(1'b1);
    n_checks++;
    if (s_ready !== 1'b1) begin n_fails++; $display("FAIL post_reset_ready got=%0b want=1", s_ready); end
    n_checks++;
    if (s_rv !== 1'b0) begin n_fails++; $display("FAIL post_reset_rsp_valid got=%0b want=0", s_rv); end
  endtask

  task automatic test_init();
    for (int i = 0; i < DEPTH; i++)
      drive(1'b0, 1'b1, 1'b1, AW'(i), '1, {$urandom, $urandom}, '0, 1'b1);
  endtask

  task automatic test_write_read();
    logic [DW-1:0] want = {BE{8'hA5}};
    drive(1'b0, 1'b1, 1'b1, AW'(5), '1, want, '0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, AW'(5), '0, '0, 8'h3C, 1'b1);
    for (int i = 1; i <= LAT; i++) begin
      idle(1'b1);
      n_checks++;
      if (s_rv !== (i == LAT)) begin
        n_fails++; $display("FAIL latency cycle=%0d rsp_valid got=%0b want=%0b", i, s_rv, (i == LAT));
      end
    end
    n_checks++;
    if (s_rd !== want || s_rt !== 8'h3C) begin
      n_fails++; $display("FAIL write_read data=%h tag=%h want data=%h tag=3c", s_rd, s_rt, want);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic test_byteen();
    logic got = 1'b0;
    drive(1'b0, 1'b1, 1'b1, AW'(7), '1, '0, '0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, AW'(7), BE'(1), 64'h1234_5678_9ABC_DEFF, '0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, AW'(7), '0, '0, 8'h11, 1'b1);
    for (int i = 0; i < 20 && !got; i++) begin
      idle(1'b1);
      if (s_rv) begin
        got = 1'b1;
        n_checks++;
        if (s_rd !== 64'h0000_0000_0000_00FF || s_rt !== 8'h11) begin
          n_fails++; $display("FAIL byteen data=%h tag=%h want data=00000000000000ff tag=11", s_rd, s_rt);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (!got) begin n_fails++; $display("FAIL byteen_timeout got=no_response want=response"); end
  endtask

  task automatic test_alias();
    logic [DW-1:0] w3 = {$urandom, $urandom};
    logic          got = 1'b0;
    drive(1'b0, 1'b1, 1'b1, AW'(3), '1, w3, '0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, AW'(DEPTH + 3), '0, '0, 8'h5A, 1'b1);
    for (int i = 0; i < 20 && !got; i++) begin
      idle(1'b1);
      if (s_rv) begin
        got = 1'b1;
        n_checks++;
        if (s_rd !== w3 || s_rt !== 8'h5A) begin
          n_fails++; $display("FAIL alias data=%h tag=%h want data=%h tag=5a", s_rd, s_rt, w3);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (!got) begin n_fails++; $display("FAIL alias_timeout got=no_response want=response"); end
  endtask

  task automatic test_backpressure();
    int   accepted = 0;
    int   got = 0;
    rsp_t e;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, AW'($urandom), '0, '0, TW'(accepted), 1'b0);
      if (!s_ready) break;
      accepted++;
    end
    n_checks++;
    if (accepted != QS) begin n_fails++; $display("FAIL bp_accepted got=%0d want=%0d", accepted, QS); end
    for (int i = 0; i < LAT + 2; i++) idle(1'b0);
    n_checks++;
    if (s_ready !== 1'b0) begin n_fails++; $display("FAIL bp_ready_held got=%0b want=0", s_ready); end
    for (int i = 0; i < 20 && got < QS; i++) begin
      idle(1'b1);
      if (s_rv) begin
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (s_rt !== TW'(got) || s_rd !== e.data) begin
          n_fails++; $display("FAIL bp_order idx=%0d tag=%h data=%h want tag=%h data=%h", got, s_rt, s_rd, TW'(got), e.data);
        end
        got++;
      end
    end
    n_checks++;
    if (got != QS) begin n_fails++; $display("FAIL bp_count got=%0d want=%0d", got, QS); end
  endtask

  task automatic test_back_to_back();
    int   issued = 0;
    int   got = 0;
    int   gaps = 0;
    int   drops = 0;
    logic seen = 1'b0;
    rsp_t e;
    for (int c = 0; c < 300 && got < 100; c++) begin
      if (issued < 100) drive(1'b0, 1'b1, 1'b0, AW'($urandom), '0, '0, TW'(issued), 1'b1);
      else idle(1'b1);
      if (issued < 100) begin
        if (s_ready) issued++;
        else drops++;
      end
      if (s_rv) begin
        seen = 1'b1;
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (s_rd !== e.data || s_rt !== e.tag) begin
          n_fails++; $display("FAIL b2b_rsp idx=%0d data=%h tag=%h want data=%h tag=%h", got, s_rd, s_rt, e.data, e.tag);
        end
        got++;
      end else if (seen) begin
        gaps++;
      end
    end
    n_checks++;
    if (got != 100) begin n_fails++; $display("FAIL b2b_count got=%0d want=100", got); end
    n_checks++;
    if (gaps != 0) begin n_fails++; $display("FAIL b2b_gaps got=%0d want=0", gaps); end
    n_checks++;
    if (drops != 0) begin n_fails++; $display("FAIL b2b_ready_drops got=%0d want=0", drops); end
  endtask

  task automatic test_random();
    logic          stalled = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [TW-1:0] pt = '0;
    logic          rr;
    rsp_t          e;
    for (int c = 0; c < 400; c++) begin
      rr = ($urandom % 3) != 0;
      drive(1'b0, ($urandom % 4) != 0, ($urandom % 3) == 0, AW'($urandom_range(0, 4 * DEPTH - 1)),
            BE'($urandom), {$urandom, $urandom}, TW'($urandom), rr);
      n_checks++;
      if (s_ready !== (pre_outstanding < QS)) begin
        n_fails++; $display("FAIL rnd_ready cycle=%0d got=%0b want=%0b", c, s_ready, (pre_outstanding < QS));
      end
      if (stalled) begin
        n_checks++;
        if (s_rv !== 1'b1 || s_rd !== pd || s_rt !== pt) begin
          n_fails++; $display("FAIL rnd_stable cycle=%0d valid=%0b data=%h tag=%h want valid=1 data=%h tag=%h", c, s_rv, s_rd, s_rt, pd, pt);
        end
      end
      if (s_rv && rr) begin
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (s_rd !== e.data || s_rt !== e.tag) begin
          n_fails++; $display("FAIL rnd_rsp cycle=%0d data=%h tag=%h want data=%h tag=%h", c, s_rd, s_rt, e.data, e.tag);
        end
      end
      stalled = s_rv && !rr;
      pd = s_rd;
      pt = s_rt;
    end
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      idle(1'b1);
      if (s_rv) begin
        n_checks++;
        e = exp_q.pop_front();
        if (s_rd !== e.data || s_rt !== e.tag) begin
          n_fails++; $display("FAIL rnd_drain data=%h tag=%h want data=%h tag=%h", s_rd, s_rt, e.data, e.tag);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL rnd_drain_left got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    logic [DW-1:0] w9 = {$urandom, $urandom};
    int            stale = 0;
    logic          got = 1'b0;
    drive(1'b0, 1'b1, 1'b1, AW'(9), '1, w9, '0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, AW'($urandom), '0, '0, TW'(i), 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
      n_checks++;
      if (s_rv !== 1'b0 || s_ready !== 1'b0) begin
        n_fails++; $display("FAIL midreset_during valid=%0b ready=%0b want 0 0", s_rv, s_ready);
      end
    end
    exp_q.delete();
    for (int i = 0; i < LAT + 6; i++) begin
      idle(1'b1);
      if (i == 0) begin
        n_checks++;
        if (s_ready !== 1'b1) begin n_fails++; $display("FAIL midreset_ready got=%0b want=1", s_ready); end
      end
      if (s_rv) stale++;
    end
    n_checks++;
    if (stale != 0) begin n_fails++; $display("FAIL midreset_stale got=%0d want=0", stale); end
    drive(1'b0, 1'b1, 1'b0, AW'(9), '0, '0, 8'h77, 1'b1);
    for (int i = 0; i < 20 && !got; i++) begin
      idle(1'b1);
      if (s_rv) begin
        got = 1'b1;
        n_checks++;
        if (s_rd !== w9 || s_rt !== 8'h77) begin
          n_fails++; $display("FAIL midreset_persist data=%h tag=%h want data=%h tag=77", s_rd, s_rt, w9);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (!got) begin n_fails++; $display("FAIL midreset_timeout got=no_response want=response"); end
  endtask

  initial begin
    reset          = 1'b1;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_addr   = '0;
    mem_req_byteen = '0;
    mem_req_data   = '0;
    mem_req_tag    = '0;
    mem_rsp_ready  = 1'b1;
    test_reset();
    test_init();
    test_write_read();
    test_byteen();
    test_alias();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_limit reached want=completion");
    $fatal(1, "watchdog");
  end

endmodule
